// File: rtl/cpu_uart_bridge.sv
// UART host bridge: loads instruction memory and reads back register-file bytes over one serial line.
// Optional macro UART_FRAME_TIMEOUT_EN aborts a partial write frame after TIMEOUT_BITS idle bit-times.
module cpu_uart_bridge #(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 9600,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_halted,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        imem_we,
    output logic [6:0]  imem_waddr,
    output logic [31:0] imem_wdata,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata
);

    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] CNT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
    localparam logic [31:0]   TO_END   = 32'(TIMEOUT_BITS * CPB - 1);

`ifdef UART_FRAME_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {P_HDR, P_B0, P_B1, P_B2, P_B3} p_state_t;

    // ---------------- receiver ----------------
    rx_state_t       rx_state, rx_next;
    logic            rx_s1, rx_s2, rx_d;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_valid;
    logic            rx_end;

    assign rx_end = (rx_cnt == CNT_END);

    always_ff @(posedge clk) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_d && !rx_s2) rx_next = RX_START;
            // Re-check mid start bit so short low glitches are rejected.
            RX_START: if (rx_cnt == HALF_END) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_end && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_end) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            rx_valid <= (rx_state == RX_STOP) && rx_end && rx_s2;
            if (rx_state == RX_IDLE || rx_state != rx_next || rx_end)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_IDLE)
                rx_bit <= '0;
            else if (rx_state == RX_DATA && rx_end) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end
    end

    // ---------------- frame parser ----------------
    p_state_t        p_state, p_next;
    logic [6:0]      hdr_addr;
    logic [23:0]     wbuf;
    logic            rd_pend;
    logic            tx_busy;
    logic [31:0]     to_cnt;
    logic            to_fire;
    tx_state_t       tx_state, tx_next;

    assign tx_busy = (tx_state != TX_IDLE) || rd_pend;
    assign to_fire = TO_EN && (to_cnt == TO_END);

    always_ff @(posedge clk) begin
        if (reset) p_state <= P_HDR;
        else       p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        case (p_state)
            P_HDR: if (rx_valid && rx_shift[7]) p_next = P_B0;
            P_B0:  if (rx_valid) p_next = P_B1; else if (to_fire) p_next = P_HDR;
            P_B1:  if (rx_valid) p_next = P_B2; else if (to_fire) p_next = P_HDR;
            P_B2:  if (rx_valid) p_next = P_B3; else if (to_fire) p_next = P_HDR;
            P_B3:  if (rx_valid) p_next = P_HDR; else if (to_fire) p_next = P_HDR;
            default: p_next = P_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_addr   <= '0;
            wbuf       <= '0;
            rd_pend    <= 1'b0;
            rf_raddr   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            to_cnt     <= '0;
        end else begin
            imem_we <= 1'b0;
            rd_pend <= 1'b0;
            if (!TO_EN || p_state == P_HDR || rx_valid)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
            if (rx_valid) begin
                case (p_state)
                    P_HDR: begin
                        hdr_addr <= rx_shift[6:0];
                        // A read that arrives while a response is still going out is dropped.
                        if (!rx_shift[7] && !tx_busy) begin
                            rf_raddr <= rx_shift[4:0];
                            rd_pend  <= 1'b1;
                        end
                    end
                    P_B0: wbuf[7:0]   <= rx_shift;
                    P_B1: wbuf[15:8]  <= rx_shift;
                    P_B2: wbuf[23:16] <= rx_shift;
                    P_B3: if (cpu_halted) begin
                        imem_we    <= 1'b1;
                        imem_waddr <= hdr_addr;
                        imem_wdata <= {rx_shift, wbuf};
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- transmitter ----------------
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shift;
    logic            tx_end;
    logic            unused_rdata;

    assign tx_end       = (tx_cnt == CNT_END);
    assign unused_rdata = ^rf_rdata[31:8];

    always_ff @(posedge clk) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (rd_pend) tx_next = TX_START;
            TX_START: if (tx_end) tx_next = TX_DATA;
            TX_DATA:  if (tx_end && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_end) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            if (tx_state == TX_IDLE || tx_end)
                tx_cnt <= '0;
            else
                tx_cnt <= tx_cnt + 1'b1;
            case (tx_state)
                TX_IDLE: if (rd_pend) begin
                    // rf_raddr was registered last cycle, so rf_rdata is now valid.
                    tx_shift <= rf_rdata[7:0];
                    tx_bit   <= '0;
                    uart_tx  <= 1'b0;
                end
                TX_START: if (tx_end) uart_tx <= tx_shift[0];
                TX_DATA: if (tx_end) begin
                    tx_bit   <= tx_bit + 1'b1;
                    tx_shift <= tx_shift >> 1;
                    uart_tx  <= (tx_bit == 3'd7) ? 1'b1 : tx_shift[1];
                end
                default: uart_tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_uart_bridge.sv
// Directed bench for cpu_uart_bridge: a host-side serial driver, a byte-level TX monitor,
// an imem write capture and a simple register-file model.
module tb_cpu_uart_bridge;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset, cpu_halted, uart_rx, uart_tx, imem_we;
    logic [6:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;

    logic [31:0] regs [32];
    logic [31:0] mem  [128];
    logic [7:0]  rxq [$];
    int          n_chk = 0, n_fail = 0;
    int          we_cnt = 0, tx_starts = 0, bad_frames = 0;
    logic [6:0]  last_addr;
    logic [31:0] last_data;
    time         t_stop, t_txs;

    always #5 clk = ~clk;
    assign rf_rdata = regs[rf_raddr];

    cpu_uart_bridge #(.CLK_HZ(1600), .BAUD(100), .TIMEOUT_BITS(40)) dut (
        .clk(clk), .reset(reset), .cpu_halted(cpu_halted), .uart_rx(uart_rx),
        .uart_tx(uart_tx), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int stop_len);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        t_stop  = $time;
        repeat (stop_len) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic wait_bytes(input int n);
        int k = 0;
        while (rxq.size() < n && k < 40 * CPB) begin
            @(negedge clk);
            k++;
        end
    endtask

    // imem write capture
    initial begin
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                we_cnt++;
                last_addr = imem_waddr;
                last_data = imem_wdata;
                mem[imem_waddr] = imem_wdata;
            end
        end
    end

    // host-side 8N1 receiver on uart_tx
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                t_txs = $time;
                tx_starts++;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                if (uart_tx === 1'b1) rxq.push_back(b);
                else bad_frames++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int sz, wc;
        reset = 1'b1;
        uart_rx = 1'b1;
        cpu_halted = 1'b0;
        for (int j = 0; j < 32; j++) regs[j] = 32'hDEADBE00 | 32'(j);
        repeat (4) @(negedge clk);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_waddr", 32'(imem_waddr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_rf_raddr", 32'(rf_raddr), 32'd0);
        reset = 1'b0;

        repeat (2000) @(negedge clk);
        chk("idle_tx_starts", 32'(tx_starts), 32'd0);
        chk("idle_we_cnt", 32'(we_cnt), 32'd0);
        chk("idle_uart_tx", 32'(uart_tx), 32'd1);

        // addi $5,$0,5 at word 5
        cpu_halted = 1'b1;
        send_byte(8'h85, 1'b1, CPB);
        send_byte(8'h05, 1'b1, CPB);
        send_byte(8'h00, 1'b1, CPB);
        send_byte(8'h05, 1'b1, CPB);
        send_byte(8'h20, 1'b1, CPB);
        repeat (4) @(negedge clk);
        chk("wr5_we_cnt", 32'(we_cnt), 32'd1);
        chk("wr5_waddr", 32'(last_addr), 32'd5);
        chk("wr5_wdata", last_data, 32'h20050005);

        // addi $j,$0,j for every register
        for (int j = 0; j < 32; j++) begin
            send_byte(8'h80 | 8'(j), 1'b1, CPB);
            send_byte(8'(j), 1'b1, CPB);
            send_byte(8'h00, 1'b1, CPB);
            send_byte(8'(j), 1'b1, CPB);
            send_byte(8'h20, 1'b1, CPB);
        end
        repeat (4) @(negedge clk);
        chk("load_we_cnt", 32'(we_cnt), 32'd33);
        for (int j = 0; j < 32; j++)
            chk($sformatf("load_mem%0d", j), mem[j], 32'h20000000 | (32'(j) << 16) | 32'(j));

        cpu_halted = 1'b0;
        repeat (50) @(negedge clk);
        cpu_halted = 1'b1;
        for (int j = 0; j < 32; j++) begin
            sz = rxq.size();
            send_byte(8'(j), 1'b1, CPB);
            wait_bytes(sz + 1);
            chk($sformatf("rd%0d_count", j), 32'(rxq.size()), 32'(sz + 1));
            if (rxq.size() > sz) chk($sformatf("rd%0d_byte", j), 32'(rxq[sz]), 32'(j));
            if (j == 0) chk("rd_latency_in_stop_bit", 32'((t_txs - t_stop) <= 10 * CPB), 32'd1);
            repeat (CPB) @(negedge clk);
        end

        // write while CPU running is discarded; read still served
        cpu_halted = 1'b0;
        wc = we_cnt;
        send_byte(8'h83, 1'b1, CPB);
        send_byte(8'hAA, 1'b1, CPB);
        send_byte(8'hBB, 1'b1, CPB);
        send_byte(8'hCC, 1'b1, CPB);
        send_byte(8'hDD, 1'b1, CPB);
        repeat (4) @(negedge clk);
        chk("run_wr_no_we", 32'(we_cnt), 32'(wc));
        sz = rxq.size();
        send_byte(8'h63, 1'b1, CPB);
        wait_bytes(sz + 1);
        chk("run_rd3_raddr", 32'(rf_raddr), 32'd3);
        if (rxq.size() > sz) chk("run_rd3_byte", 32'(rxq[sz]), 32'd3);
        else chk("run_rd3_count", 32'(rxq.size()), 32'(sz + 1));
        repeat (CPB) @(negedge clk);

        // framing error: no response, parser stays in header state
        sz = rxq.size();
        send_byte(8'h07, 1'b0, CPB);
        repeat (25 * CPB) @(negedge clk);
        chk("badstop_rd_none", 32'(rxq.size()), 32'(sz));
        send_byte(8'h85, 1'b0, CPB);
        send_byte(8'h04, 1'b1, CPB);
        wait_bytes(sz + 1);
        if (rxq.size() > sz) chk("badstop_hdr_rd4", 32'(rxq[sz]), 32'd4);
        else chk("badstop_hdr_count", 32'(rxq.size()), 32'(sz + 1));
        repeat (CPB) @(negedge clk);

        // short low glitch on the line
        sz = rxq.size();
        wc = we_cnt;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (25 * CPB) @(negedge clk);
        chk("glitch_no_tx", 32'(rxq.size()), 32'(sz));
        send_byte(8'h06, 1'b1, CPB);
        wait_bytes(sz + 1);
        if (rxq.size() > sz) chk("glitch_then_rd6", 32'(rxq[sz]), 32'd6);
        else chk("glitch_then_count", 32'(rxq.size()), 32'(sz + 1));
        repeat (CPB) @(negedge clk);

        // second read arrives while the first response is still on the wire
        sz = rxq.size();
        send_byte(8'h01, 1'b1, 12);
        send_byte(8'h02, 1'b1, CPB);
        repeat (30 * CPB) @(negedge clk);
        chk("busy_one_resp", 32'(rxq.size()), 32'(sz + 1));
        if (rxq.size() > sz) chk("busy_first_byte", 32'(rxq[sz]), 32'd1);

        // partial write frame followed by a long gap
        cpu_halted = 1'b1;
        sz = rxq.size();
        wc = we_cnt;
        send_byte(8'h81, 1'b1, CPB);
        send_byte(8'h11, 1'b1, CPB);
        repeat (50 * CPB) @(negedge clk);
`ifdef UART_FRAME_TIMEOUT_EN
        send_byte(8'h02, 1'b1, CPB);
        wait_bytes(sz + 1);
        if (rxq.size() > sz) chk("to_rd2_byte", 32'(rxq[sz]), 32'd2);
        else chk("to_rd2_count", 32'(rxq.size()), 32'(sz + 1));
        chk("to_no_we", 32'(we_cnt), 32'(wc));
`else
        send_byte(8'h02, 1'b1, CPB);
        send_byte(8'h03, 1'b1, CPB);
        send_byte(8'h04, 1'b1, CPB);
        repeat (25 * CPB) @(negedge clk);
        chk("noto_we_cnt", 32'(we_cnt), 32'(wc + 1));
        chk("noto_waddr", 32'(last_addr), 32'd1);
        chk("noto_wdata", last_data, 32'h04030211);
        chk("noto_no_resp", 32'(rxq.size()), 32'(sz));
`endif
        chk("bad_tx_frames", 32'(bad_frames), 32'd0);

        // reset in the middle of a response
        wc = tx_starts;
        send_byte(8'h1F, 1'b1, CPB);
        repeat (10 * CPB) @(negedge clk);
        chk("midrst_tx_started", 32'(tx_starts), 32'(wc + 1));
        repeat (3 * CPB) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_uart_tx_high", 32'(uart_tx), 32'd1);
        chk("midrst_rf_raddr", 32'(rf_raddr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12 * CPB) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
